// File: rtl/aes_pkg.sv
// Shared helpers for the Rijndael ShiftRows datapath: legal block widths,
// per-row rotation offsets and byte positions within the packed state.
package aes_pkg;

  // Direction of the row rotation.
  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_INV = 1'b1
  } dir_e;

  localparam int ROWS = 4;

  // True for the Rijndael block widths this datapath supports.
  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // Rotation amount of row r; the 256-bit block uses a wider spread.
  function automatic int shift_off(input int nb, input int r);
    case (r)
      0:       return 0;
      1:       return 1;
      2:       return (nb == 8) ? 3 : 2;
      default: return (nb == 8) ? 4 : 3;
    endcase
  endfunction

  // LSB position of byte s_i; s_0 sits at the top of the vector.
  function automatic int byte_lsb(input int nb, input int i);
    return 32 * nb - 8 - 8 * i;
  endfunction

  // Index of the input byte that lands in output byte i.
  function automatic int src_byte(input int nb, input int i, input dir_e dir);
    int r;
    int c;
    int sc;
    r = i % ROWS;
    c = i / ROWS;
    if (dir == DIR_INV) sc = (c - shift_off(nb, r) + nb) % nb;
    else                sc = (c + shift_off(nb, r)) % nb;
    return r + ROWS * sc;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for an NB-column
// state. Pure wiring plus one 2:1 mux per byte; reusable wherever a state
// needs rotating (round datapath, key schedule, unrolled rounds).
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic              inv_i,
  input  logic [32*NB-1:0]  data_i,
  output logic [32*NB-1:0]  data_o
);

  logic [32*NB-1:0] fwd_map;
  logic [32*NB-1:0] inv_map;

  for (genvar i = 0; i < 4 * NB; i++) begin : g_byte
    localparam int DST   = byte_lsb(NB, i);
    localparam int SRC_F = byte_lsb(NB, src_byte(NB, i, DIR_FWD));
    localparam int SRC_I = byte_lsb(NB, src_byte(NB, i, DIR_INV));
    assign fwd_map[DST +: 8] = data_i[SRC_F +: 8];
    assign inv_map[DST +: 8] = data_i[SRC_I +: 8];
  end

  // Direction select per block.
  assign data_o = inv_i ? inv_map : fwd_map;

endmodule

// File: rtl/shift_rows_pipe.sv
// Pipelined ShiftRows / InvShiftRows stage with valid/ready flow control.
// Optional per-byte parity is enabled with the macro SHIFT_ROWS_PARITY_EN.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Each stage loads when it is empty or its block is leaving this
// cycle (ready = !valid_q || next_ready). Valid must not depend on ready.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB          = 4,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32*NB-1:0]  in_data,
  input  logic              in_inv,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag
`ifdef SHIFT_ROWS_PARITY_EN
  ,
  input  logic [4*NB-1:0]   in_par,
  output logic [4*NB-1:0]   out_par,
  output logic              par_err
`endif
);

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_stages
    $error("shift_rows_pipe: PIPE_STAGES must be 1 or 2");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("shift_rows_pipe: TAG_W must be at least 1");
  end

  logic [32*NB-1:0] perm_data;

  shift_rows_perm #(.NB(NB)) u_perm (
    .inv_i  (in_inv),
    .data_i (in_data),
    .data_o (perm_data)
  );

  // Stage 1: permuted block.
  logic              s1_valid_q, s1_valid_d;
  logic [32*NB-1:0]  s1_data_q,  s1_data_d;
  logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;
  logic              s1_next_ready;
  logic              s1_ready;

  assign s1_ready = !s1_valid_q || s1_next_ready;
  assign in_ready = s1_ready;

  // Stage 1 next state: capture the permuted block whenever the slot frees up.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_tag_d   = s1_tag_q;
    if (s1_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = perm_data;
        s1_tag_d  = in_tag;
      end
    end
  end

  // Stage 1 registers; reset empties the slot and clears the payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_tag_q   <= s1_tag_d;
    end
  end

`ifdef SHIFT_ROWS_PARITY_EN
  logic [4*NB-1:0] perm_par;
  logic [4*NB-1:0] byte_bad;
  logic [4*NB-1:0] s1_par_q, s1_par_d;
  logic            par_err_q, par_err_d;

  // Parity bits follow their bytes; each is also rechecked against its byte.
  for (genvar i = 0; i < 4 * NB; i++) begin : g_par
    localparam int SF = src_byte(NB, i, DIR_FWD);
    localparam int SI = src_byte(NB, i, DIR_INV);
    assign perm_par[i] = in_inv ? in_par[SI] : in_par[SF];
    assign byte_bad[i] = in_par[i] ^ (^in_data[byte_lsb(NB, i) +: 8]);
  end

  // Parity next state: travels with stage 1; error is sticky on a bad accept.
  always_comb begin
    s1_par_d  = s1_par_q;
    par_err_d = par_err_q;
    if (s1_ready && in_valid) begin
      s1_par_d  = perm_par;
      par_err_d = par_err_q | (|byte_bad);
    end
  end

  // Parity registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_par_q  <= '0;
      par_err_q <= 1'b0;
    end else begin
      s1_par_q  <= s1_par_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`endif

  if (PIPE_STAGES == 2) begin : g_stage2
    // Stage 2: plain register slice for timing.
    logic              s2_valid_q, s2_valid_d;
    logic [32*NB-1:0]  s2_data_q,  s2_data_d;
    logic [TAG_W-1:0]  s2_tag_q,   s2_tag_d;
    logic              s2_ready;

    assign s2_ready      = !s2_valid_q || out_ready;
    assign s1_next_ready = s2_ready;

    // Stage 2 next state: take stage 1's block whenever this slot frees up.
    always_comb begin
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_tag_d   = s2_tag_q;
      if (s2_ready) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_data_d = s1_data_q;
          s2_tag_d  = s1_tag_q;
        end
      end
    end

    // Stage 2 registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
        s2_tag_q   <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_data_q  <= s2_data_d;
        s2_tag_q   <= s2_tag_d;
      end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;

`ifdef SHIFT_ROWS_PARITY_EN
    logic [4*NB-1:0] s2_par_q, s2_par_d;

    // Stage 2 parity next state.
    always_comb begin
      s2_par_d = s2_par_q;
      if (s2_ready && s1_valid_q) s2_par_d = s1_par_q;
    end

    // Stage 2 parity register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s2_par_q <= '0;
      else        s2_par_q <= s2_par_d;
    end

    assign out_par = s2_par_q;
`endif
  end else begin : g_stage1_only
    assign s1_next_ready = out_ready;
    assign out_valid     = s1_valid_q;
    assign out_data      = s1_data_q;
    assign out_tag       = s1_tag_q;
`ifdef SHIFT_ROWS_PARITY_EN
    assign out_par       = s1_par_q;
`endif
  end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised, pipelined AES/Rijndael ShiftRows / InvShiftRows stage with a valid/ready handshake.
- Supports Rijndael block widths Nb = 4, 6 and 8 columns. The direction (forward or inverse) is selected per transfer.
- Sits between SubBytes and MixColumns in the round datapath. A sideband tag travels with each block so the round controller can track blocks in flight.

Parameters:
- NB, 4, state columns (4, 6 or 8 only); data width is 32*NB.
- PIPE_STAGES, 1, register stages (1 or 2); stage 2 is a pure register slice for timing.
- TAG_W, 4, sideband tag width (>= 1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  stage can accept a block.
- in_data  in  32*NB  state; byte s_i (i = row + 4*col) at bits [32*NB-1-8i -: 8].
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows.
- in_tag  in  TAG_W  sideband, passed through unmodified.
- out_valid  out  1  output block valid.
- out_ready  in  1  downstream accepts.
- out_data  out  32*NB  permuted state, same byte layout as in_data.
- out_tag  out  TAG_W  tag of the block on out_data.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Row offsets C_r, r = 0..3:
  - NB = 4 or 6: (0, 1, 2, 3).
  - NB = 8: (0, 1, 3, 4).
- Forward permutation: out[r][c] = in[r][(c + C_r) mod NB].
- Inverse permutation: out[r][c] = in[r][(c - C_r) mod NB], using modulo-NB wrap.
- Stage 1 registers the permuted data and the tag. Stage 2, when present, registers stage 1 unchanged.
- Each stage holds a valid bit. A stage loads when it is empty or when its contents are leaving this cycle: stage_ready = !stage_valid || next_ready.
  - in_ready is stage 1's stage_ready.
  - The last stage's next_ready is out_ready.
- Latency is exactly PIPE_STAGES cycles from an in_valid && in_ready edge to out_valid. Throughput is 1 block/cycle with no bubbles while out_ready = 1.
- in_ready is combinational from out_ready and the valid bits. There is no combinational path from in_* to out_*.
- Stall: while out_valid && !out_ready, out_data and out_tag hold stable and no block is dropped or duplicated. in_ready deasserts only when all stages are full.
- Simultaneous accept and drain in a full pipe is allowed and keeps full throughput.
- in_inv is sampled only on the accept edge. Changing it while not accepted has no effect.
- Reset: all valid bits are 0. out_valid = 0, out_data = 0, out_tag = 0. in_ready = 1 after reset.
- Reset mid-operation discards all in-flight blocks immediately.
- Elaboration error on NB outside {4, 6, 8}, or PIPE_STAGES outside {1, 2}.

Optional Feature:
- Macro SHIFT_ROWS_PARITY_EN.
- When defined:
  - Adds input in_par [4*NB], holding even parity per byte with bit i for byte s_i.
  - Adds output out_par [4*NB], permuted identically to the data bytes.
  - Adds output par_err [1]. It goes sticky-high one cycle after any accepted block whose in_par mismatches the recomputed byte parity. It is cleared only by rst_n.
  - The data path is unaffected by a parity error.
- When undefined: these ports do not exist and there is no parity logic.

Decomposition:
- Package aes_pkg:
  - NB-dependent row-offset function shift_off(nb, r).
  - Legal-NB check.
  - Byte-index helper function byte_lsb(nb, i).
- Sub-module shift_rows_perm: purely combinational, parameters NB and inverse-select input, generate-loop byte mapping. It is used by this block and reusable in key-schedule or unrolled-round datapaths.

Test Plan:
- NB=4, forward, FIPS-197 App. B round 1: in_data d42711aee0bf98f1b8b45de51e415230 -> out_data d4bf5d30e0b452aeb84111f11e2798e5 after PIPE_STAGES cycles.
- NB=4, in_inv=1, in_data d4bf5d30e0b452aeb84111f11e2798e5 -> d42711aee0bf98f1b8b45de51e415230. Randomised forward-then-inverse round-trip returns identity for NB = 4, 6, 8.
- NB=8, forward, byte s_i = i (00..1f) -> out column 0 bytes = 00 05 0e 13. Full vector is checked against the reference model.
- Back-to-back stream of 16 blocks, out_ready=1 -> 16 consecutive out_valid cycles, tags 0..15 in order, in_ready never low.
- out_ready held 0 for 5 cycles with PIPE_STAGES=2 -> in_ready low after 2 accepts, out_data stable. On release, all blocks emerge in order with no loss.
- rst_n pulsed low mid-stream with blocks in flight -> out_valid=0 and out_data=0 immediately (asynchronously). First post-reset block has nominal latency. With SHIFT_ROWS_PARITY_EN, a single flipped in_par bit sets par_err, which stays set until reset.
